// File: rtl/audio_in_deserializer.sv
// Serial ADC audio deserializer: one shared shift register
// feeding independent left/right show-ahead word FIFOs.

module audio_in_fifo #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          write,
  input  logic [DATA_WIDTH-1:0]         write_data,
  input  logic                          read,
  output logic [DATA_WIDTH-1:0]         read_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   used,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int UW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [UW-1:0]         count;
  logic                  ovf;
  logic                  do_rd;
  logic                  do_wr;

  assign empty     = (count == '0);
  assign full      = (count == UW'(FIFO_DEPTH));
  assign used      = count;
  assign overflow  = ovf;
  assign read_data = mem[rd_ptr];

  // A read frees a slot in the same cycle, so a full FIFO
  // can still accept a write when it is also being read.
  assign do_rd = read & ~empty;
  assign do_wr = write & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_rd)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + UW'(do_wr) - UW'(do_rd);
      if (write & full & ~read)
        ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !reset)
      mem[wr_ptr] <= write_data;
  end

endmodule

module audio_in_deserializer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        bit_clk_rising_edge,
  input  logic                        left_right_clk_rising_edge,
  input  logic                        left_right_clk_falling_edge,
  input  logic                        counting,
  input  logic                        serial_audio_in_data,
  input  logic                        read_left_channel,
  input  logic                        read_right_channel,
  output logic [DATA_WIDTH-1:0]       left_channel_data,
  output logic [DATA_WIDTH-1:0]       right_channel_data,
  output logic                        left_channel_fifo_empty,
  output logic                        right_channel_fifo_empty,
  output logic                        left_channel_fifo_full,
  output logic                        right_channel_fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] left_channel_fifo_used,
  output logic [$clog2(FIFO_DEPTH):0] right_channel_fifo_used,
  output logic                        left_channel_overflow,
  output logic                        right_channel_overflow
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH:0]   shifted;
  logic [CW-1:0]         cap_cnt;
  logic                  word_done;
  logic                  lr_edge;
  logic                  write_left;
  logic                  write_right;

  assign word_done = (cap_cnt == CW'(DATA_WIDTH));
  assign shifted   = {shift_reg, serial_audio_in_data};
  assign lr_edge   = left_right_clk_rising_edge |
                     left_right_clk_falling_edge;

  // Coincident LR edges count as a left-frame end only.
  assign write_left  = left_right_clk_rising_edge & word_done;
  assign write_right = left_right_clk_falling_edge &
                       ~left_right_clk_rising_edge & word_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      cap_cnt   <= '0;
    end else if (lr_edge) begin
      shift_reg <= '0;
      cap_cnt   <= '0;
    end else if (bit_clk_rising_edge && counting && !word_done) begin
      shift_reg <= shifted[DATA_WIDTH-1:0];
      cap_cnt   <= cap_cnt + CW'(1);
    end
  end

  audio_in_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_left_fifo (
    .clk        (clk),
    .reset      (reset),
    .write      (write_left),
    .write_data (shift_reg),
    .read       (read_left_channel),
    .read_data  (left_channel_data),
    .empty      (left_channel_fifo_empty),
    .full       (left_channel_fifo_full),
    .used       (left_channel_fifo_used),
    .overflow   (left_channel_overflow)
  );

  audio_in_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_right_fifo (
    .clk        (clk),
    .reset      (reset),
    .write      (write_right),
    .write_data (shift_reg),
    .read       (read_right_channel),
    .read_data  (right_channel_data),
    .empty      (right_channel_fifo_empty),
    .full       (right_channel_fifo_full),
    .used       (right_channel_fifo_used),
    .overflow   (right_channel_overflow)
  );

endmodule

// File: tb/tb_audio_in_deserializer.sv
// Scoreboard bench for audio_in_deserializer:
// frames in, expected words queued, compared at the FIFO heads.

module tb_audio_in_deserializer;

  localparam int DW = 24;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          bit_clk_rising_edge;
  logic          left_right_clk_rising_edge;
  logic          left_right_clk_falling_edge;
  logic          counting;
  logic          serial_audio_in_data;
  logic          read_left_channel;
  logic          read_right_channel;
  logic [DW-1:0] left_channel_data;
  logic [DW-1:0] right_channel_data;
  logic          left_channel_fifo_empty;
  logic          right_channel_fifo_empty;
  logic          left_channel_fifo_full;
  logic          right_channel_fifo_full;
  logic [3:0]    left_channel_fifo_used;
  logic [3:0]    right_channel_fifo_used;
  logic          left_channel_overflow;
  logic          right_channel_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_l[$];
  logic [DW-1:0] exp_r[$];
  bit            exp_ovf_l;
  bit            exp_ovf_r;

  always #5 clk = ~clk;

  audio_in_deserializer #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                         (clk),
    .reset                       (reset),
    .bit_clk_rising_edge         (bit_clk_rising_edge),
    .left_right_clk_rising_edge  (left_right_clk_rising_edge),
    .left_right_clk_falling_edge (left_right_clk_falling_edge),
    .counting                    (counting),
    .serial_audio_in_data        (serial_audio_in_data),
    .read_left_channel           (read_left_channel),
    .read_right_channel          (read_right_channel),
    .left_channel_data           (left_channel_data),
    .right_channel_data          (right_channel_data),
    .left_channel_fifo_empty     (left_channel_fifo_empty),
    .right_channel_fifo_empty    (right_channel_fifo_empty),
    .left_channel_fifo_full      (left_channel_fifo_full),
    .right_channel_fifo_full     (right_channel_fifo_full),
    .left_channel_fifo_used      (left_channel_fifo_used),
    .right_channel_fifo_used     (right_channel_fifo_used),
    .left_channel_overflow       (left_channel_overflow),
    .right_channel_overflow      (right_channel_overflow)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input logic b, input logic c);
    serial_audio_in_data = b;
    counting = c;
    bit_clk_rising_edge = 1'b1;
    tick();
    bit_clk_rising_edge = 1'b0;
    tick();
  endtask

  // nbits valid MSB-first bits, then junk slots still counting,
  // then a few junk bit edges with counting low.
  task automatic send_bits(input logic [DW-1:0] w,
                           input int nbits,
                           input int njunk);
    for (int i = 0; i < nbits; i++) slot(w[DW-1-i], 1'b1);
    for (int i = 0; i < njunk; i++) slot(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) slot(1'b1, 1'b0);
  endtask

  task automatic lr(input logic rise, input logic fall,
                    input logic rd_l);
    left_right_clk_rising_edge  = rise;
    left_right_clk_falling_edge = fall;
    read_left_channel = rd_l;
    tick();
    left_right_clk_rising_edge  = 1'b0;
    left_right_clk_falling_edge = 1'b0;
    read_left_channel = 1'b0;
  endtask

  task automatic push_l(input logic [DW-1:0] w);
    if (exp_l.size() < DEPTH) exp_l.push_back(w);
    else exp_ovf_l = 1'b1;
  endtask

  task automatic left_word(input logic [DW-1:0] w);
    send_bits(w, DW, 8);
    push_l(w);
    lr(1'b1, 1'b0, 1'b0);
  endtask

  task automatic pop_l();
    logic [DW-1:0] e;
    e = exp_l.pop_front();
    chk("l_data", {8'h0, left_channel_data}, {8'h0, e});
    read_left_channel = 1'b1;
    tick();
    read_left_channel = 1'b0;
  endtask

  task automatic pop_r();
    logic [DW-1:0] e;
    e = exp_r.pop_front();
    chk("r_data", {8'h0, right_channel_data}, {8'h0, e});
    read_right_channel = 1'b1;
    tick();
    read_right_channel = 1'b0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_l_used"}, 32'(left_channel_fifo_used),
        32'(exp_l.size()));
    chk({tag, "_r_used"}, 32'(right_channel_fifo_used),
        32'(exp_r.size()));
    chk({tag, "_l_empty"}, 32'(left_channel_fifo_empty),
        32'(exp_l.size() == 0));
    chk({tag, "_r_empty"}, 32'(right_channel_fifo_empty),
        32'(exp_r.size() == 0));
    chk({tag, "_l_full"}, 32'(left_channel_fifo_full),
        32'(exp_l.size() == DEPTH));
    chk({tag, "_r_full"}, 32'(right_channel_fifo_full),
        32'(exp_r.size() == DEPTH));
    chk({tag, "_l_ovf"}, 32'(left_channel_overflow), 32'(exp_ovf_l));
    chk({tag, "_r_ovf"}, 32'(right_channel_overflow), 32'(exp_ovf_r));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_l.delete();
    exp_r.delete();
    exp_ovf_l = 1'b0;
    exp_ovf_r = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bit_clk_rising_edge = 1'b0;
    left_right_clk_rising_edge = 1'b0;
    left_right_clk_falling_edge = 1'b0;
    counting = 1'b0;
    serial_audio_in_data = 1'b0;
    read_left_channel = 1'b0;
    read_right_channel = 1'b0;
    tick();
    do_reset();
    chk_state("rst");

    // Partial first frame after reset is discarded.
    send_bits(24'hFFFFFF, 7, 0);
    lr(1'b1, 1'b0, 1'b0);
    tick();
    chk_state("partial");

    // Full left word with 8 trailing junk slots.
    left_word(24'hA5A5A5);
    chk_state("a5");
    pop_l();
    chk_state("a5_drain");

    // Right half-frame with only 10 captured bits.
    send_bits(24'h3C3C3C, 10, 0);
    lr(1'b0, 1'b1, 1'b0);
    tick();
    chk_state("r_short");

    // Nine left words, no reads: ninth dropped.
    for (int i = 1; i <= 9; i++) left_word(24'(i));
    chk_state("fill9");
    chk("fill9_head", {8'h0, left_channel_data}, 32'h1);

    // Write into a full FIFO with a same-cycle read.
    do_reset();
    for (int i = 0; i < DEPTH; i++) left_word(24'h110 + 24'(i));
    chk_state("full8");
    send_bits(24'h1FF, DW, 8);
    void'(exp_l.pop_front());
    exp_l.push_back(24'h1FF);
    lr(1'b1, 1'b0, 1'b1);
    chk_state("wr_rd_full");
    while (exp_l.size() > 0) pop_l();
    chk_state("drain8");

    // Reads on an empty right FIFO must not move pointers.
    for (int i = 0; i < 3; i++) begin
      read_right_channel = 1'b1;
      tick();
    end
    read_right_channel = 1'b0;
    chk_state("r_empty_rd");
    send_bits(24'h5A5A5A, DW, 8);
    exp_r.push_back(24'h5A5A5A);
    lr(1'b0, 1'b1, 1'b0);
    chk_state("r_word");
    pop_r();

    // Both LR edges together act as a left-frame end.
    send_bits(24'h77_1234, DW, 0);
    push_l(24'h771234);
    lr(1'b1, 1'b1, 1'b0);
    chk_state("both_lr");
    pop_l();

    // Reset mid-frame with 3 words held and overflow set.
    for (int i = 1; i <= 9; i++) left_word(24'h200 + 24'(i));
    for (int i = 0; i < 5; i++) pop_l();
    chk_state("pre_rst");
    send_bits(24'hFFFFFF, 12, 0);
    do_reset();
    chk_state("mid_rst");
    left_word(24'h123456);
    send_bits(24'h654321, DW, 8);
    exp_r.push_back(24'h654321);
    lr(1'b0, 1'b1, 1'b0);
    chk_state("post_rst");
    pop_l();
    pop_r();
    chk_state("end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_in_deserializer.md
AUDIO_IN_DESERIALIZER -- requirements
Module: audio_in_deserializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, meaning bits captured per channel word (legal 1..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning words per channel FIFO (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port bit_clk_rising_edge  input  1  one-clk pulse at serial bit clock rising edge.
REQ-006 SHALL have port left_right_clk_rising_edge  input  1  one-clk pulse, end of left half-frame.
REQ-007 SHALL have port left_right_clk_falling_edge  input  1  one-clk pulse, end of right half-frame.
REQ-008 SHALL have port counting  input  1  high while upstream bit counter marks valid data bit slots.
REQ-009 SHALL have port serial_audio_in_data  input  1  serial ADC data, MSB first.
REQ-010 SHALL have ports read_left_channel / read_right_channel  input  1 each  pop head of respective FIFO.
REQ-011 SHALL have ports left_channel_data / right_channel_data  output  DATA_WIDTH each  head word of respective FIFO (show-ahead).
REQ-012 SHALL have ports left_channel_fifo_empty / right_channel_fifo_empty  output  1 each  FIFO holds no words.
REQ-013 SHALL have ports left_channel_fifo_full / right_channel_fifo_full  output  1 each  FIFO holds FIFO_DEPTH words.
REQ-014 SHALL have ports left_channel_fifo_used / right_channel_fifo_used  output  log2(FIFO_DEPTH)+1 each  word count.
REQ-015 SHALL have ports left_channel_overflow / right_channel_overflow  output  1 each  sticky, a word was dropped.

Function
REQ-016 SHALL hold a DATA_WIDTH shift register and a capture counter 0..DATA_WIDTH.
REQ-017 SHALL, on bit_clk_rising_edge with counting=1 and capture counter < DATA_WIDTH, shift left inserting serial_audio_in_data at LSB and increment capture counter.
REQ-018 SHALL ignore bit edges when counting=0 or capture counter = DATA_WIDTH (extra slot bits discarded).
REQ-019 SHALL, on left_right_clk_rising_edge, write shift register to left FIFO if capture counter = DATA_WIDTH, then clear shift register and capture counter.
REQ-020 SHALL, on left_right_clk_falling_edge, do the same into right FIFO.
REQ-021 SHALL discard incomplete words (capture counter < DATA_WIDTH) without overflow flag; covers first partial frame after reset.
REQ-022 SHALL give LR edge priority over a same-cycle bit edge: write uses pre-shift contents, that bit is not captured.
REQ-023 SHALL treat both LR edges in one cycle as rising only.
REQ-024 SHALL make a written word visible at FIFO output, empty deassert and used increment on the cycle after the write cycle.
REQ-025 SHALL, on read with FIFO non-empty, advance head; next word (or empty=1) visible next cycle.
REQ-026 SHALL ignore read when empty; no underflow, pointers unchanged.
REQ-027 SHALL, on write when full and no same-cycle read, drop word and set channel overflow to 1 until reset.
REQ-028 SHALL, on simultaneous write and read when full, perform both; used stays FIFO_DEPTH, no overflow.
REQ-029 SHALL, on simultaneous write and read when empty, perform write only; used becomes 1.
REQ-030 SHALL wrap FIFO pointers modulo FIFO_DEPTH; used = write count minus read count, never exceeds FIFO_DEPTH.
REQ-031 SHALL keep channels fully independent except for the shared shift register.

Reset
REQ-032 SHALL, when reset=1 at a clk edge, clear shift register, capture counter, both FIFOs' pointers and counts, and both overflow flags; reset wins over any same-cycle event.
REQ-033 SHALL drive after reset: fifo_empty=1, fifo_full=0, fifo_used=0, overflow=0 both channels; channel_data don't-care while empty.
REQ-034 SHALL discard any word in progress when reset asserts mid-frame.

Verification
REQ-035 SHALL test: left half-frame, 32 bit slots, counting high, serial 0xA5A5A5 then 8 junk bits, LR rising -> next cycle left_channel_data=0xA5A5A5, left empty=0, used=1; right FIFO untouched.
REQ-036 SHALL test: right half-frame only 10 bits captured before LR falling -> right FIFO stays empty, overflow=0.
REQ-037 SHALL test: 9 left words 0x000001..0x000009, no reads -> used=8, full=1, left_channel_overflow=1, head=0x000001.
REQ-038 SHALL test: full FIFO, read_left_channel asserted in same cycle as LR rising write -> used=8, overflow=0, head=second word.
REQ-039 SHALL test: read_right_channel pulses on empty FIFO -> used=0, empty=1, no pointer movement (later write reads back correctly).
REQ-040 SHALL test: reset asserted after 12 captured bits, with 3 words in left FIFO and overflow set -> all outputs at reset values next cycle; following full frame writes correctly.
